// File: rtl/var_delay_line.sv
// Multi-lane run-time programmable delay line: addressable SRL tap plus one output register.
// Optional occupancy counter output o_occ is enabled by defining VAR_DELAY_LINE_OCC_EN.
module var_delay_line #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4,
  parameter int MAX_DEPTH  = 16,
  parameter int DLY_W      = $clog2(MAX_DEPTH + 1)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_ce,
  input  logic                         i_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
  input  logic                         i_dly_ld,
  input  logic [DLY_W-1:0]             i_dly,
  output logic                         o_valid,
  output logic [NUM_CH*DATA_WIDTH-1:0] o_data,
  output logic                         o_primed,
  output logic [DLY_W-1:0]             o_dly
`ifdef VAR_DELAY_LINE_OCC_EN
  ,
  output logic [DLY_W-1:0]             o_occ
`endif
);

  localparam int BUS_W = NUM_CH * DATA_WIDTH;
  localparam int SRL_N = MAX_DEPTH - 1;

  typedef enum logic {FILL, RUN} state_t;

  state_t           state, state_nxt;
  logic [DLY_W-1:0] fill_cnt, fill_cnt_nxt;

  logic [BUS_W-1:0] srl_p0 [SRL_N];
  logic [SRL_N-1:0] vld_p0;

  logic [DLY_W-1:0] tap_idx;
  logic [BUS_W-1:0] tap_data;
  logic             tap_vld;

  function automatic logic [DLY_W-1:0] clamp_dly(input logic [DLY_W-1:0] d);
    if (d < DLY_W'(2))
      return DLY_W'(2);
    else if (d > DLY_W'(MAX_DEPTH))
      return DLY_W'(MAX_DEPTH);
    else
      return d;
  endfunction

  // Stage p0: SRL shift (no reset) and tap select at L-2
  always_ff @(posedge i_clk) begin
    if (i_ce) begin
      srl_p0[0] <= i_data;
      for (int k = 1; k < SRL_N; k++)
        srl_p0[k] <= srl_p0[k-1];
    end
  end

  always_comb begin
    tap_idx  = o_dly - DLY_W'(2);
    tap_data = srl_p0[0];
    tap_vld  = vld_p0[0];
    for (int k = 1; k < SRL_N; k++) begin
      if (tap_idx == DLY_W'(k)) begin
        tap_data = srl_p0[k];
        tap_vld  = vld_p0[k];
      end
    end
  end

  // Stage p1: output register
  always_ff @(posedge i_clk) begin
    if (i_ce)
      o_data <= tap_data;
  end

  // A reload flushes every in-flight valid and drops the sample at the load edge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p0  <= '0;
      o_valid <= 1'b0;
      o_dly   <= DLY_W'(MAX_DEPTH);
    end else if (i_dly_ld) begin
      vld_p0  <= '0;
      o_valid <= 1'b0;
      o_dly   <= clamp_dly(i_dly);
    end else if (i_ce) begin
      vld_p0  <= (vld_p0 << 1) | SRL_N'(i_valid);
      o_valid <= tap_vld;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= FILL;
      fill_cnt <= '0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= fill_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fill_cnt_nxt = fill_cnt;
    if (i_dly_ld) begin
      state_nxt    = FILL;
      fill_cnt_nxt = '0;
    end else if (i_ce) begin
      case (state)
        FILL: begin
          if (fill_cnt == o_dly - DLY_W'(1))
            state_nxt = RUN;
          else
            fill_cnt_nxt = fill_cnt + DLY_W'(1);
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  assign o_primed = (state == RUN);

`ifdef VAR_DELAY_LINE_OCC_EN
  // Samples in flight: SRL stages plus the output register
  always_ff @(posedge i_clk) begin
    if (i_rst || i_dly_ld) begin
      o_occ <= '0;
    end else if (i_ce) begin
      if (i_valid && !o_valid && o_occ < DLY_W'(MAX_DEPTH))
        o_occ <= o_occ + DLY_W'(1);
      else if (!i_valid && o_valid && o_occ != '0)
        o_occ <= o_occ - DLY_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_var_delay_line.sv
// Randomized scoreboard bench for var_delay_line: samples are scheduled to emerge
// a fixed number of enabled edges after capture, and an independent monitor compares.
module tb_var_delay_line;

  localparam int DW    = 8;
  localparam int NCH   = 4;
  localparam int MAXD  = 16;
  localparam int DLYW  = $clog2(MAXD + 1);
  localparam int BUSW  = DW * NCH;

  logic            clk = 1'b0;
  logic            rst, ce, vld, ld;
  logic [BUSW-1:0] din;
  logic [DLYW-1:0] dly;
  logic            o_valid, o_primed;
  logic [BUSW-1:0] o_data;
  logic [DLYW-1:0] o_dly;
`ifdef VAR_DELAY_LINE_OCC_EN
  logic [DLYW-1:0] o_occ;
`endif

  int checks = 0;
  int errors = 0;

  var_delay_line #(.DATA_WIDTH(DW), .NUM_CH(NCH), .MAX_DEPTH(MAXD)) dut (
    .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_valid(vld), .i_data(din),
    .i_dly_ld(ld), .i_dly(dly), .o_valid(o_valid), .o_data(o_data),
    .o_primed(o_primed), .o_dly(o_dly)
`ifdef VAR_DELAY_LINE_OCC_EN
    , .o_occ(o_occ)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BUSW-1:0] d;
    int              due;
  } ent_t;

  ent_t            sb[$];
  int              ecnt = 0;
  int              cur_l = MAXD;
  bit              started = 0;
  bit              edge_en = 0;
  bit              edge_flush = 0;
  bit              exp_ovld = 0;
  logic            prev_vld;
  logic [BUSW-1:0] prev_data;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
    end
  endfunction

  function automatic int clamp(input int d);
    if (d < 2) return 2;
    if (d > MAXD) return MAXD;
    return d;
  endfunction

  // Reference: a sample captured on enabled edge n appears after enabled edge n+L-1
  always @(posedge clk) begin
    edge_en    = 0;
    edge_flush = 0;
    if (rst) begin
      sb.delete(); ecnt = 0; cur_l = MAXD; edge_flush = 1; exp_ovld = 0; started = 1;
    end else if (ld) begin
      sb.delete(); ecnt = 0; cur_l = clamp(int'(dly)); edge_flush = 1; exp_ovld = 0;
    end else if (ce) begin
      ecnt++;
      edge_en = 1;
      if (vld) sb.push_back('{d: din, due: ecnt + cur_l - 1});
    end
  end

  always @(negedge clk) begin
    bit exp_v;
    if (started) begin
      chk("o_dly", 64'(o_dly), 64'(cur_l));
      chk("o_primed", 64'(o_primed), 64'(ecnt >= cur_l));
      if (edge_flush) begin
        chk("o_valid_flush", 64'(o_valid), 64'd0);
      end else if (edge_en) begin
        while (sb.size() > 0 && sb[0].due < ecnt) begin
          chk("missed_sample", 64'(sb[0].due), 64'(ecnt));
          void'(sb.pop_front());
        end
        exp_v = (sb.size() > 0 && sb[0].due == ecnt);
        chk("o_valid", 64'(o_valid), 64'(exp_v));
        if (exp_v) begin
          chk("o_data", 64'(o_data), 64'(sb[0].d));
          void'(sb.pop_front());
        end
        exp_ovld = exp_v;
      end else begin
        chk("hold_valid", 64'(o_valid), 64'(prev_vld));
        chk("hold_data", 64'(o_data), 64'(prev_data));
      end
`ifdef VAR_DELAY_LINE_OCC_EN
      chk("o_occ", 64'(o_occ), 64'(sb.size() + int'(exp_ovld)));
`endif
      prev_vld  = o_valid;
      prev_data = o_data;
    end
  end

  task automatic cyc(input logic r, input logic c, input logic v,
                     input logic [BUSW-1:0] d, input logic l, input int dl);
    rst = r; ce = c; vld = v; din = d; ld = l; dly = DLYW'(dl);
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int n, input int ce_pct, input int v_pct);
    for (int i = 0; i < n; i++)
      cyc(1'b0, ($urandom % 100) < ce_pct, ($urandom % 100) < v_pct, $urandom, 1'b0, 0);
  endtask

  initial begin
    logic [BUSW-1:0] d;
    rst = 1'b1; ce = 1'b0; vld = 1'b0; din = '0; ld = 1'b0; dly = '0;
    repeat (3) cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, 0);

    // Directed burst at L=5
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b1, 5);
    for (int i = 1; i <= 3; i++) begin
      d = $urandom; d[7:0] = 8'(i);
      cyc(1'b0, 1'b1, 1'b1, d, 1'b0, 0);
    end
    stream(8, 100, 0);

    // Clamping extremes
    cyc(1'b0, 1'b1, 1'b1, $urandom, 1'b1, 0);
    stream(20, 100, 60);
    cyc(1'b0, 1'b1, 1'b1, $urandom, 1'b1, 31);
    stream(40, 100, 60);

    // Alternating clock enable at L=4
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b1, 4);
    for (int i = 0; i < 30; i++)
      cyc(1'b0, i[0] == 1'b0, 1'b1, $urandom, 1'b0, 0);

    // Reload during a stream, together with a valid sample
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b1, 8);
    stream(20, 100, 100);
    cyc(1'b0, 1'b1, 1'b1, $urandom, 1'b1, 3);
    stream(20, 100, 70);

    // Reset with samples in flight, simultaneous with a load
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b1, 8);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b1, $urandom, 1'b0, 0);
    cyc(1'b1, 1'b1, 1'b1, $urandom, 1'b1, 3);
    stream(20, 70, 0);

    // Reload with the same L still flushes
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b1, 6);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, $urandom, 1'b0, 0);
    stream(2, 100, 0);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, 6);
    stream(12, 100, 0);

    // Randomized soak
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom % 1000;
      cyc(r < 5, ($urandom % 100) < 75, ($urandom % 2) == 1, $urandom,
          r >= 5 && r < 35, $urandom_range(0, 31));
    end
    stream(40, 100, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
